// File: rtl/down_counter_enabled.sv
// Enabled down-counter: counts INPUT_MAX down to 0 on en_i-gated beats and
// pulses done_o in the terminal cycle. It can optionally start the next countdown by itself.
module down_counter_enabled #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned INPUT_MAX   = 10,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 en_i,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 busy_o,
  output logic                 done_o
);

  if (INPUT_MAX == 0 || (WORD_SIZE < 32 && INPUT_MAX >= (32'd1 << WORD_SIZE))) begin : gBadParam
    $error("down_counter_enabled: INPUT_MAX must lie in 1 .. 2**WORD_SIZE-1");
  end

  localparam logic [WORD_SIZE-1:0] MaxValue = WORD_SIZE'(INPUT_MAX);
  localparam logic [WORD_SIZE-1:0] OneValue = WORD_SIZE'(1);

  typedef enum logic [1:0] {eIDLE, eCOUNTING, eTERMINAL} state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 busy_q, done_q;
  state_e               startState;
  logic [WORD_SIZE-1:0] startData;

  // A start (from idle or terminal) consumes a beat immediately when en_i is high.
  assign startData  = en_i ? (MaxValue - OneValue) : MaxValue;
  assign startState = (en_i && INPUT_MAX == 1) ? eTERMINAL : eCOUNTING;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      eIDLE: begin
        if (start_i) begin
          state_d = startState;
          data_d  = startData;
        end
      end
      eCOUNTING: begin
        if (en_i) begin
          data_d = data_q - OneValue;
          if (data_q == OneValue) state_d = eTERMINAL;
        end
      end
      eTERMINAL: begin
        if (start_i || AUTO_RELOAD) begin
          state_d = startState;
          data_d  = startData;
        end else begin
          state_d = eIDLE;
          data_d  = MaxValue;
        end
      end
      default: begin
        state_d = eIDLE;
        data_d  = MaxValue;
      end
    endcase
  end

  // Status flags are registered alongside the state so they never see inputs combinationally.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eIDLE;
      data_q  <= MaxValue;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      busy_q  <= (state_d == eCOUNTING);
      done_q  <= (state_d == eTERMINAL);
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_down_counter_enabled.sv
// Drives four counter configurations from shared inputs and compares each
// against a count-based reference model every cycle.
module tb_down_counter_enabled;

  localparam int NumDut = 4;

  logic clk;
  logic resetIn;
  logic startIn;
  logic enIn;

  logic [15:0] dataObs [NumDut];
  logic        busyObs [NumDut];
  logic        doneObs [NumDut];

  int maxOf [NumDut] = '{10, 1, 1, 3};
  bit arOf  [NumDut] = '{1'b0, 1'b0, 1'b1, 1'b1};

  int modelValue   [NumDut];
  bit modelRunning [NumDut];

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  down_counter_enabled #(.WORD_SIZE(16), .INPUT_MAX(10), .AUTO_RELOAD(1'b0)) u10 (
    .clk_i(clk), .reset_i(resetIn), .start_i(startIn), .en_i(enIn),
    .data_o(dataObs[0]), .busy_o(busyObs[0]), .done_o(doneObs[0]));

  down_counter_enabled #(.WORD_SIZE(16), .INPUT_MAX(1), .AUTO_RELOAD(1'b0)) u1 (
    .clk_i(clk), .reset_i(resetIn), .start_i(startIn), .en_i(enIn),
    .data_o(dataObs[1]), .busy_o(busyObs[1]), .done_o(doneObs[1]));

  down_counter_enabled #(.WORD_SIZE(16), .INPUT_MAX(1), .AUTO_RELOAD(1'b1)) u1Auto (
    .clk_i(clk), .reset_i(resetIn), .start_i(startIn), .en_i(enIn),
    .data_o(dataObs[2]), .busy_o(busyObs[2]), .done_o(doneObs[2]));

  down_counter_enabled #(.WORD_SIZE(16), .INPUT_MAX(3), .AUTO_RELOAD(1'b1)) u3Auto (
    .clk_i(clk), .reset_i(resetIn), .start_i(startIn), .en_i(enIn),
    .data_o(dataObs[3]), .busy_o(busyObs[3]), .done_o(doneObs[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a countdown is a remaining-value plus a "running" flag; zero means terminal.
  task automatic modelReset();
    for (int i = 0; i < NumDut; i++) begin
      modelValue[i]   = maxOf[i];
      modelRunning[i] = 1'b0;
    end
  endtask

  task automatic modelStep(input bit r, input bit s, input bit e);
    for (int i = 0; i < NumDut; i++) begin
      if (r) begin
        modelValue[i]   = maxOf[i];
        modelRunning[i] = 1'b0;
      end else if (modelValue[i] == 0) begin
        if (s || arOf[i]) begin
          modelRunning[i] = 1'b1;
          modelValue[i]   = e ? maxOf[i] - 1 : maxOf[i];
        end else begin
          modelRunning[i] = 1'b0;
          modelValue[i]   = maxOf[i];
        end
      end else if (modelRunning[i]) begin
        if (e) modelValue[i] = modelValue[i] - 1;
      end else if (s) begin
        modelRunning[i] = 1'b1;
        if (e) modelValue[i] = modelValue[i] - 1;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [15:0] expData;
    logic        expBusy;
    logic        expDone;
    for (int i = 0; i < NumDut; i++) begin
      expData = 16'(modelValue[i]);
      expDone = (modelValue[i] == 0);
      expBusy = modelRunning[i] && (modelValue[i] != 0);
      checkCount++;
      assert (dataObs[i] === expData) passCount++;
      else begin
        failCount++;
        $error("[TB] FAIL %s data inst%0d: observed %0d expected %0d", tag, i, dataObs[i], expData);
      end
      checkCount++;
      assert (busyObs[i] === expBusy) passCount++;
      else begin
        failCount++;
        $error("[TB] FAIL %s busy inst%0d: observed %b expected %b", tag, i, busyObs[i], expBusy);
      end
      checkCount++;
      assert (doneObs[i] === expDone) passCount++;
      else begin
        failCount++;
        $error("[TB] FAIL %s done inst%0d: observed %b expected %b", tag, i, doneObs[i], expDone);
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit e, input string tag);
    @(negedge clk);
    resetIn = r;
    startIn = s;
    enIn    = e;
    @(posedge clk);
    modelStep(r, s, e);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    bit pendingRestart;
    resetIn = 1'b1;
    startIn = 1'b0;
    enIn    = 1'b0;
    modelReset();

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 1'b0, "reset");
    applyStimulus(1'b1, 1'b1, 1'b1, "resetOverride");
    applyStimulus(1'b0, 1'b0, 1'b0, "idle");

    $display("[TB] full countdown with en held high");
    applyStimulus(1'b0, 1'b1, 1'b1, "start");
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b0, 1'b1, "countEn");

    $display("[TB] countdown with toggling enable");
    applyStimulus(1'b0, 1'b1, 1'b1, "startToggle");
    for (int k = 0; k < 22; k++) applyStimulus(1'b0, 1'b0, k[0], "countToggle");

    $display("[TB] mid-count start ignored, back-to-back restart at terminal");
    applyStimulus(1'b0, 1'b1, 1'b1, "startB2B");
    pendingRestart = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (modelValue[0] == 5) begin
        applyStimulus(1'b0, 1'b1, 1'b1, "midStart");
      end else if (modelValue[0] == 0 && pendingRestart) begin
        pendingRestart = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, "b2bRestart");
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b1, "b2bCount");
      end
    end

    $display("[TB] reset during a countdown");
    applyStimulus(1'b0, 1'b1, 1'b1, "startReset");
    for (int k = 0; k < 20 && modelValue[0] != 4; k++) applyStimulus(1'b0, 1'b0, 1'b1, "toFour");
    applyStimulus(1'b1, 1'b0, 1'b1, "midReset");
    applyStimulus(1'b0, 1'b1, 1'b1, "startAfterReset");
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b0, 1'b1, "countAfterReset");

    $display("[TB] randomized stimulus");
    for (int k = 0; k < 2000; k++) begin
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 3,
                    $urandom_range(0, 9) < 7, "random");
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/down_counter_enabled.md
Name: down_counter_enabled

Overview:
Enabled down-counter: the counting-down counterpart of the team's enabled up-counter. On start it counts from INPUT_MAX down to 0 inclusive, advancing only when en_i is high. It flags the terminal count with a one-cycle done pulse. It drives reverse-order addressing and countdown sequencing in the CNN/FIR datapath, for example draining buffers last-to-first and counting remaining taps.

Parameters:
WORD_SIZE, 16, width of data_o; must hold INPUT_MAX.
INPUT_MAX, 10, start/reload value; legal range 1 to 2^WORD_SIZE-1.
AUTO_RELOAD, 0, if 1, a new countdown starts automatically after terminal count without start_i.

Ports:
clk_i  input  1  clock; all logic on rising edge.
reset_i  input  1  synchronous, active-high reset.
start_i  input  1  begin a countdown; sampled in eIDLE and eTERMINAL only.
en_i  input  1  count enable; decrement happens only when high.
data_o  output  WORD_SIZE  current count, registered.
busy_o  output  1  high while state is eCOUNTING.
done_o  output  1  one-cycle pulse, high while state is eTERMINAL (data_o == 0).

Behaviour:
- Interface: one clock, clk_i. reset_i is synchronous and active-high.
- Reset: state eIDLE, data_o = INPUT_MAX, busy_o = 0, done_o = 0. Reset asserted mid-count returns to these values at the next edge; it overrides start_i and en_i.
- States: eIDLE, eCOUNTING, eTERMINAL. busy_o and done_o decode the registered state only, with no combinational path from inputs.
- eIDLE, data_o holds INPUT_MAX:
  - start_i && en_i: data_o <= INPUT_MAX-1. Next state is eTERMINAL if INPUT_MAX == 1, else eCOUNTING.
  - start_i && !en_i: data_o holds; next state eCOUNTING.
  - otherwise: stay in eIDLE.
- eCOUNTING:
  - en_i: data_o <= data_o-1. If data_o == 1, next state eTERMINAL, else stay.
  - !en_i: data_o holds and the state holds. The terminal transition is en-gated.
  - start_i is ignored; no restart mid-count.
- eTERMINAL, data_o == 0, done_o = 1 for exactly this cycle. The state is left unconditionally after one cycle; en_i does not stall it.
  - start_i, or AUTO_RELOAD == 1: behave exactly like start in eIDLE (en_i ? INPUT_MAX-1 : INPUT_MAX, then eCOUNTING, or eTERMINAL when INPUT_MAX == 1 with en_i). This gives back-to-back countdowns with no idle cycle.
  - otherwise: data_o <= INPUT_MAX; next state eIDLE.
- Arithmetic: unsigned, WORD_SIZE bits. data_o never wraps below 0: decrement is impossible at 0 because eTERMINAL always reloads.
- Latency: with en_i held high from the start cycle:
  - data_o is INPUT_MAX-k at k cycles after the start edge.
  - done_o is high INPUT_MAX cycles after the start edge.
- Each en-gated decrement corresponds to one consumed beat. A full countdown is INPUT_MAX decrements plus the start value INPUT_MAX, i.e. INPUT_MAX+1 distinct values.
- Elaboration: an assertion fails if INPUT_MAX == 0 or INPUT_MAX ≥ 2^WORD_SIZE.

Test Plan:
- Reset, then start_i for 1 cycle, en_i = 1 always, INPUT_MAX = 10: data_o = 10,9,...,0 on successive edges; done_o high only the cycle data_o = 0; busy_o high for 9 cycles; data_o returns to 10 and state to eIDLE.
- Same start, en_i toggling 1,0,1,0: data_o changes only on en_i-high edges (10,9,9,8,8,...). Terminal is reached after 10 enabled beats; no done_o while en_i is low at data_o = 1.
- start_i high in the eTERMINAL cycle with en_i = 1: next data_o = 9 with no eIDLE cycle between; a second done_o occurs 10 cycles later. Also check that start_i pulsed mid-count (data_o = 5) has no effect.
- reset_i at data_o = 4 while en_i = 1: next edge data_o = 10, busy_o = 0, done_o = 0; a subsequent start_i runs a full, normal countdown.
- INPUT_MAX = 1, start_i && en_i: data_o 1 → 0 with done_o the next cycle, then reload to 1. With AUTO_RELOAD = 1 and en_i stuck high, data_o alternates 0,0? No: it alternates 0 (done_o) and reloads as 0 again each cycle, so done_o stays continuously high.
- AUTO_RELOAD = 1, INPUT_MAX = 3, one start_i, en_i = 1: data_o = 3,2,1,0,2,1,0,2,...; done_o pulses every 3 cycles; busy_o is low only in eTERMINAL cycles.
